// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants, state encoding and Cause merge helper for the CP0
// exception sequencer.
package cp0_exc_ctrl_pkg;

   localparam int          REG_BUS        = 32;

   localparam logic [4:0]  CP0_ADDR_STATUS = 5'd12;
   localparam logic [4:0]  CP0_ADDR_CAUSE  = 5'd13;
   localparam logic [4:0]  CP0_ADDR_EPC    = 5'd14;

   localparam int          STATUS_IE_BIT  = 0;
   localparam int          STATUS_EXL_BIT = 1;
   localparam int          CAUSE_BD_BIT   = 31;
   localparam int          EXC_CODE_LSB   = 2;
   localparam int          EXC_CODE_MSB   = 6;

   localparam logic [REG_BUS-1:0] EXC_VECTOR   = 32'h0000_0020;
   localparam logic [4:0]         EXC_CODE_INT = 5'd0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_EPC    = 3'd1,
      S_W_CAUSE  = 3'd2,
      S_W_STATUS = 3'd3,
      S_W_ERET   = 3'd4,
      S_FLUSH    = 3'd5
   } exc_state_t;

   // Read-modify-write of Cause: only BD and ExcCode are replaced, so
   // pending interrupt bits and the software bits survive.
   function automatic logic [REG_BUS-1:0] cause_merge(
      input logic               bd,
      input logic [REG_BUS-1:0] cause,
      input logic [4:0]         code
   );
      return {bd, cause[30:7], code, cause[1:0]};
   endfunction

endpackage

// File: rtl/cp0_exc_ctrl_prio.sv
// IDLE-state request decode: interrupt > exception > eret > mtc0.
module cp0_exc_ctrl_prio
   import cp0_exc_ctrl_pkg::*;
(
   input  logic       int_pend_i,
   input  logic       exc_req_i,
   input  logic [4:0] exc_code_i,
   input  logic       eret_i,
   input  logic       mtc0_we_i,
   output logic       take_trap_o,
   output logic       take_eret_o,
   output logic       take_mtc0_o,
   output logic [4:0] trap_code_o
);

   always_comb begin
      take_trap_o = int_pend_i | exc_req_i;
      take_eret_o = ~take_trap_o & eret_i;
      take_mtc0_o = ~take_trap_o & ~eret_i & mtc0_we_i;
      trap_code_o = int_pend_i ? EXC_CODE_INT : exc_code_i;
   end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: owns the CP0 write port, serialises
// EPC/Cause/Status updates for traps and eret, then flushes and redirects.
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid_i,
   input  logic        exc_req_i,
   input  logic [4:0]  exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic        exc_in_delay_i,
   input  logic        eret_i,
   input  logic        mtc0_we_i,
   input  logic [4:0]  mtc0_addr_i,
   input  logic [31:0] mtc0_data_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_wdata_o,
   output logic        stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   exc_state_t  r_state;
   exc_state_t  w_state_next;
   logic [4:0]  r_code;
   logic        r_bd;
   logic [31:0] r_epc;
   logic [31:0] r_new_pc;

   logic        w_int_pend;
   logic        w_idle;
   logic        w_take_trap;
   logic        w_take_eret;
   logic        w_take_mtc0;
   logic [4:0]  w_trap_code;
   logic        w_unused_cause;

   assign w_unused_cause = ^{cause_i[31], cause_i[6:2]};

   assign w_int_pend = (|(cause_i[15:8] & status_i[15:8]))
                     & status_i[STATUS_IE_BIT]
                     & ~status_i[STATUS_EXL_BIT]
                     & inst_valid_i;

   // Requests are only looked at in IDLE; the stalled MEM stage holds them otherwise.
   assign w_idle = (r_state == S_IDLE) & rst;

   cp0_exc_ctrl_prio u_prio (
      .int_pend_i  (w_int_pend),
      .exc_req_i   (exc_req_i),
      .exc_code_i  (exc_code_i),
      .eret_i      (eret_i),
      .mtc0_we_i   (mtc0_we_i),
      .take_trap_o (w_take_trap),
      .take_eret_o (w_take_eret),
      .take_mtc0_o (w_take_mtc0),
      .trap_code_o (w_trap_code)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_code   <= '0;
         r_bd     <= 1'b0;
         r_epc    <= '0;
         r_new_pc <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_idle && w_take_trap) begin
            r_code <= w_trap_code;
            r_bd   <= exc_in_delay_i;
            r_epc  <= exc_in_delay_i ? (exc_pc_i - 32'd4) : exc_pc_i;
         end
         if (r_state == S_W_STATUS)
            r_new_pc <= EXC_VECTOR;
         else if (r_state == S_W_ERET)
            r_new_pc <= epc_i;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_take_trap)
               w_state_next = status_i[STATUS_EXL_BIT] ? S_W_CAUSE : S_W_EPC;
            else if (w_take_eret)
               w_state_next = S_W_ERET;
         end
         S_W_EPC:    w_state_next = S_W_CAUSE;
         S_W_CAUSE:  w_state_next = S_W_STATUS;
         S_W_STATUS: w_state_next = S_FLUSH;
         S_W_ERET:   w_state_next = S_FLUSH;
         S_FLUSH:    w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      cp0_we_o    = 1'b0;
      cp0_waddr_o = '0;
      cp0_wdata_o = '0;
      stall_o     = 1'b0;
      flush_o     = 1'b0;
      new_pc_o    = '0;
      if (rst) begin
         case (r_state)
            S_IDLE: begin
               stall_o = w_take_trap | w_take_eret;
               if (w_take_mtc0) begin
                  cp0_we_o    = 1'b1;
                  cp0_waddr_o = mtc0_addr_i;
                  cp0_wdata_o = mtc0_data_i;
               end
            end
            S_W_EPC: begin
               stall_o     = 1'b1;
               cp0_we_o    = 1'b1;
               cp0_waddr_o = CP0_ADDR_EPC;
               cp0_wdata_o = r_epc;
            end
            S_W_CAUSE: begin
               stall_o     = 1'b1;
               cp0_we_o    = 1'b1;
               cp0_waddr_o = CP0_ADDR_CAUSE;
               cp0_wdata_o = cause_merge(r_bd, cause_i, r_code);
            end
            S_W_STATUS: begin
               stall_o     = 1'b1;
               cp0_we_o    = 1'b1;
               cp0_waddr_o = CP0_ADDR_STATUS;
               cp0_wdata_o = status_i | 32'h0000_0002;
            end
            S_W_ERET: begin
               stall_o     = 1'b1;
               cp0_we_o    = 1'b1;
               cp0_waddr_o = CP0_ADDR_STATUS;
               cp0_wdata_o = status_i & ~32'h0000_0002;
            end
            S_FLUSH: begin
               stall_o  = 1'b1;
               flush_o  = 1'b1;
               new_pc_o = r_new_pc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: traps, nesting, interrupt priority, eret,
// mtc0 pass-through and mid-sequence reset.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_valid_i = 1'b0;
   logic        exc_req_i = 1'b0;
   logic [4:0]  exc_code_i = '0;
   logic [31:0] exc_pc_i = '0;
   logic        exc_in_delay_i = 1'b0;
   logic        eret_i = 1'b0;
   logic        mtc0_we_i = 1'b0;
   logic [4:0]  mtc0_addr_i = '0;
   logic [31:0] mtc0_data_i = '0;
   logic [31:0] status_i = '0;
   logic [31:0] cause_i = '0;
   logic [31:0] epc_i = '0;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_wdata_o;
   logic        stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cp0_exc_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .inst_valid_i   (inst_valid_i),
      .exc_req_i      (exc_req_i),
      .exc_code_i     (exc_code_i),
      .exc_pc_i       (exc_pc_i),
      .exc_in_delay_i (exc_in_delay_i),
      .eret_i         (eret_i),
      .mtc0_we_i      (mtc0_we_i),
      .mtc0_addr_i    (mtc0_addr_i),
      .mtc0_data_i    (mtc0_data_i),
      .status_i       (status_i),
      .cause_i        (cause_i),
      .epc_i          (epc_i),
      .cp0_we_o       (cp0_we_o),
      .cp0_waddr_o    (cp0_waddr_o),
      .cp0_wdata_o    (cp0_wdata_o),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .new_pc_o       (new_pc_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic we, input logic [4:0] addr,
                       input logic [31:0] data, input logic stall, input logic flush,
                       input logic [31:0] pc);
      chk({tag, ".we"},    {31'd0, cp0_we_o}, {31'd0, we});
      chk({tag, ".addr"},  {27'd0, cp0_waddr_o}, {27'd0, addr});
      chk({tag, ".data"},  cp0_wdata_o, data);
      chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, stall});
      chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, flush});
      chk({tag, ".newpc"}, new_pc_o, pc);
      $display("step %-14s we=%0d addr=%0d data=%h stall=%0d flush=%0d pc=%h",
               tag, cp0_we_o, cp0_waddr_o, cp0_wdata_o, stall_o, flush_o, new_pc_o);
   endtask

   // Advance one clock and let combinational outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      exc_req_i = 1'b0; eret_i = 1'b0; mtc0_we_i = 1'b0;
      exc_in_delay_i = 1'b0; inst_valid_i = 1'b0;
   endtask

   initial begin
      #12;
      outs("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      outs("idle", 0, 0, 0, 0, 0, 0);

      // Syscall
      status_i = 32'h1000_0001; cause_i = 32'h0;
      exc_req_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h0040_0010; inst_valid_i = 1;
      #1 outs("sys.c0", 0, 0, 0, 1, 0, 0);
      tick(); clear_req();
      #1 outs("sys.c1", 1, 14, 32'h0040_0010, 1, 0, 0);
      tick(); outs("sys.c2", 1, 13, 32'h0000_0020, 1, 0, 0);
      tick(); outs("sys.c3", 1, 12, 32'h1000_0003, 1, 0, 0);
      tick(); outs("sys.c4", 0, 0, 0, 1, 1, 32'h0000_0020);
      tick(); outs("sys.c5", 0, 0, 0, 0, 0, 0);

      // Delay-slot trap
      exc_req_i = 1; exc_code_i = 5'd4; exc_pc_i = 32'h0040_0024; exc_in_delay_i = 1;
      #1 outs("ds.c0", 0, 0, 0, 1, 0, 0);
      tick(); clear_req();
      #1 outs("ds.c1", 1, 14, 32'h0040_0020, 1, 0, 0);
      tick(); outs("ds.c2", 1, 13, 32'h8000_0010, 1, 0, 0);
      tick(); outs("ds.c3", 1, 12, 32'h1000_0003, 1, 0, 0);
      tick(); outs("ds.c4", 0, 0, 0, 1, 1, 32'h0000_0020);
      tick(); outs("ds.c5", 0, 0, 0, 0, 0, 0);

      // Nested trap, EXL already set
      status_i = 32'h1000_0003;
      exc_req_i = 1; exc_code_i = 5'd12; exc_pc_i = 32'h0040_0030;
      #1 outs("nest.c0", 0, 0, 0, 1, 0, 0);
      tick(); clear_req();
      #1 outs("nest.c1", 1, 13, 32'h0000_0030, 1, 0, 0);
      tick(); outs("nest.c2", 1, 12, 32'h1000_0003, 1, 0, 0);
      tick(); outs("nest.c3", 0, 0, 0, 1, 1, 32'h0000_0020);
      tick(); outs("nest.c4", 0, 0, 0, 0, 0, 0);

      // Interrupt beats exception and mtc0
      status_i = 32'h1000_0401; cause_i = 32'h0000_0400; inst_valid_i = 1;
      exc_req_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h0040_0040;
      mtc0_we_i = 1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'h100;
      #1 outs("irq.c0", 0, 0, 0, 1, 0, 0);
      tick(); clear_req();
      #1 outs("irq.c1", 1, 14, 32'h0040_0040, 1, 0, 0);
      tick(); outs("irq.c2", 1, 13, 32'h0000_0400, 1, 0, 0);
      tick(); outs("irq.c3", 1, 12, 32'h1000_0403, 1, 0, 0);
      tick(); outs("irq.c4", 0, 0, 0, 1, 1, 32'h0000_0020);
      tick(); outs("irq.c5", 0, 0, 0, 0, 0, 0);

      // eret
      status_i = 32'h1000_0003; cause_i = 32'h0; epc_i = 32'h0040_0100; eret_i = 1;
      #1 outs("eret.c0", 0, 0, 0, 1, 0, 0);
      tick(); clear_req();
      #1 outs("eret.c1", 1, 12, 32'h1000_0001, 1, 0, 0);
      tick(); outs("eret.c2", 0, 0, 0, 1, 1, 32'h0040_0100);
      tick(); outs("eret.c3", 0, 0, 0, 0, 0, 0);

      // mtc0 pass-through
      status_i = 32'h1000_0001;
      mtc0_we_i = 1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'h100;
      #1 outs("mtc0", 1, 11, 32'h0000_0100, 0, 0, 0);
      tick(); clear_req();
      #1 outs("mtc0.after", 0, 0, 0, 0, 0, 0);

      // Reset during W_CAUSE
      exc_req_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h0040_0050;
      #1 outs("rst.c0", 0, 0, 0, 1, 0, 0);
      tick(); clear_req();
      #1 outs("rst.c1", 1, 14, 32'h0040_0050, 1, 0, 0);
      tick(); outs("rst.c2", 1, 13, 32'h0000_0020, 1, 0, 0);
      rst = 1'b0;
      #1 outs("rst.asserted", 0, 0, 0, 0, 0, 0);
      tick(); rst = 1'b1;
      #1 outs("rst.release", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         outs($sformatf("rst.noflush%0d", i), 0, 0, 0, 0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception and interrupt sequencer for the CP0 block: it owns CP0's single write port and arbitrates it among the MEM-stage exception, interrupt, eret and mtc0 sources. It turns one trap or eret into an ordered series of CP0 register writes (EPC, then Cause, then Status). It stalls the pipeline while the series runs, then issues a one-cycle flush with the redirect PC. It sits between the MEM stage, the CP0 register block and the pipeline control block.

## Interface
- EXC_VECTOR, 32'h00000020, redirect PC for every exception and interrupt.
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_valid_i  in  1  MEM stage holds a real, committable instruction.
- exc_req_i  in  1  synchronous exception raised by the MEM-stage instruction.
- exc_code_i  in  5  ExcCode for exc_req_i.
- exc_pc_i  in  32  PC of the MEM-stage instruction.
- exc_in_delay_i  in  1  MEM-stage instruction sits in a branch delay slot.
- eret_i  in  1  MEM-stage instruction is eret.
- mtc0_we_i, mtc0_addr_i[4:0], mtc0_data_i[31:0]  in  MEM-stage mtc0 write request.
- status_i, cause_i, epc_i  in  32 each  live CP0 Status, Cause and EPC values.
- cp0_we_o  out  1  CP0 write enable.
- cp0_waddr_o  out  5  CP0 write address.
- cp0_wdata_o  out  32  CP0 write data.
- stall_o  out  1  freeze the pipeline.
- flush_o  out  1  one-cycle pipeline flush.
- new_pc_o  out  32  redirect PC; valid only while flush_o is high.

## Operation
- Interrupt pending: `(cause_i[15:8] & status_i[15:8]) != 0 && status_i[0] (IE) && !status_i[1] (EXL) && inst_valid_i`.
- Priority when the FSM is in IDLE: interrupt > exc_req_i > eret_i > mtc0_we_i.
  - An interrupt uses ExcCode 0.
  - Whenever a trap or eret is accepted, the same-cycle mtc0 is dropped.
- Capture on acceptance (registers): code, BD, and EPC value.
  - EPC value = exc_pc_i − 4 when exc_in_delay_i is set, otherwise exc_pc_i.
- FSM states: IDLE, W_EPC, W_CAUSE, W_STATUS, W_ERET, FLUSH.
- IDLE transitions:
  - On a trap with EXL=0, go to W_EPC.
  - On a trap with EXL=1, go to W_CAUSE; EPC is left unchanged.
  - On eret, go to W_ERET.
  - On mtc0, pass it straight through to the write port: `cp0_we_o=1` with the mtc0 address and data, no stall, and stay in IDLE.
- W_EPC: write addr 14 with the captured EPC value, then go to W_CAUSE.
- W_CAUSE: write addr 13 with `{BD, cause_i[30:7], code, cause_i[1:0]}`, then go to W_STATUS.
  - The Cause value is a read-modify-write of the live cause_i, so interrupt bits in [15:10] are preserved.
- W_STATUS: write addr 12 with `status_i | 32'h2`, then go to FLUSH with new_pc = EXC_VECTOR.
- W_ERET: write addr 12 with `status_i & ~32'h2`, then go to FLUSH.
  - new_pc = epc_i, sampled in this state.
- FLUSH: `flush_o=1`, new_pc_o driven, no CP0 write; then return to IDLE.
- While not in IDLE, all requests are ignored. The pipeline is stalled, so the MEM stage holds them.
- Only one CP0 write per cycle; the write port is never contended.

## Timing
- Reset values: state IDLE, all captured registers 0, and every output 0 (cp0_we_o, cp0_waddr_o, cp0_wdata_o, stall_o, flush_o, new_pc_o).
- Write-port outputs and stall_o are combinational from the state and registers. In IDLE they are also combinational from the inputs.
- Trap accepted in cycle 0 (EXL=0):
  - Cycle 0: stall_o=1 (combinational in IDLE).
  - Cycle 1: EPC write.
  - Cycle 2: Cause write.
  - Cycle 3: Status write.
  - Cycle 4: flush_o=1.
  - Cycle 5: IDLE, stall_o=0.
- Trap with EXL=1: same sequence one cycle shorter; flush_o is in cycle 3.
- eret: cycle 1 Status write, cycle 2 flush_o, cycle 3 IDLE.
- stall_o is high from the acceptance cycle through the FLUSH cycle inclusive. It is low in the FLUSH+1 cycle.
- mtc0: zero latency; the write lands on the same clock edge.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. The partial write series is abandoned and no flush is issued.

## Structure
- defines.v (shared include) holds:
  - CP0 register addresses: EPC 14, Status 12, Cause 13.
  - Bit positions for EXL, IE, BD and the ExcCode field.
  - FSM state encodings.
  - EXC_VECTOR default.
  - RegBus.
- Single flat module; no sub-module is needed. Optional helper: `exc_prio_enc` for the IDLE priority decode.

## Test plan
- Syscall: exc_req_i=1, code 8, pc 0x00400010, no delay slot, status 0x10000001 → required response:
  - Writes in order: EPC=0x00400010, Cause[6:2]=8 with BD=0, Status=0x10000003.
  - flush_o with new_pc_o=0x00000020 in cycle 4.
  - stall_o high for cycles 0–4.
- Delay-slot trap: pc 0x00400024 with exc_in_delay_i=1 → EPC=0x00400020 and Cause[31]=1.
- Nested trap: status EXL=1, exc_req_i code 12 → no EPC write; Cause then Status writes; flush_o in cycle 3.
- Interrupt beats exception and mtc0: cause[10]=1, status=0x10000401, and exc_req_i plus mtc0_we_i asserted in the same cycle → result:
  - ExcCode 0 is written.
  - The mtc0 never appears on the write port.
- eret: status 0x10000003, epc_i 0x00400100 → Status write 0x10000001, then flush_o with new_pc_o=0x00400100.
- mtc0 to Compare (addr 11, data 0x100) in IDLE → cp0_we_o=1 in the same cycle, stall_o=0. Then assert reset in the W_CAUSE state of a trap → all outputs 0 at once, and no flush follows.
